// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: the comb section runs at the low input rate, samples are
// zero-stuffed by R = 2**STG_GSZ, and the integrator section runs on out_rate strobes.
module cic_interpolator #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned STG_GSZ    = 5,
  parameter int unsigned ISZ        = 16,
  localparam int unsigned OSZ       = ISZ + (NUM_STAGES - 1) * STG_GSZ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_rate,
  input  logic                  out_rate,
  input  logic signed [ISZ-1:0] in,
  output logic signed [OSZ-1:0] out,
  output logic                  out_valid,
  output logic                  overrun
);

  logic signed [OSZ-1:0] comb_c [NUM_STAGES+1];
  logic signed [OSZ-1:0] comb_d [NUM_STAGES];
  logic        [NUM_STAGES:0] comb_en;
  logic signed [OSZ-1:0] integ [NUM_STAGES];
  logic signed [OSZ-1:0] hold;
  logic                  pending;
  logic signed [OSZ-1:0] addend_c;

  // Comb section: each stage fires one clk after the previous, following the enable chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      comb_en <= '0;
      for (int j = 0; j <= int'(NUM_STAGES); j++) comb_c[j] <= '0;
      for (int j = 0; j < int'(NUM_STAGES); j++) comb_d[j] <= '0;
    end else begin
      comb_en <= {comb_en[NUM_STAGES-1:0], in_rate};
      if (in_rate) begin
        comb_c[0] <= OSZ'(in);
        comb_d[0] <= comb_c[0];
      end
      for (int j = 1; j <= int'(NUM_STAGES); j++) begin
        if (comb_en[j-1]) comb_c[j] <= comb_c[j-1] - comb_d[j-1];
      end
      for (int j = 1; j < int'(NUM_STAGES); j++) begin
        if (comb_en[j-1]) comb_d[j] <= comb_c[j];
      end
    end
  end

  // Zero-stuff: a held comb result is injected once, on the first out_rate after capture.
  always_comb begin
    addend_c = '0;
    if (pending) addend_c = hold;
  end

  // A same-edge out_rate consumes the old pending state while the new result becomes pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (comb_en[NUM_STAGES]) begin
        hold    <= comb_c[NUM_STAGES];
        pending <= 1'b1;
        if (pending && !out_rate) overrun <= 1'b1;
      end else if (out_rate) begin
        pending <= 1'b0;
      end
    end
  end

  // Integrator cascade, advanced only on out_rate; wraparound is intended.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) integ[i] <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_rate;
      if (out_rate) begin
        integ[0] <= integ[0] + addend_c;
        for (int i = 1; i < int'(NUM_STAGES); i++) integ[i] <= integ[i] + integ[i-1];
      end
    end
  end

  assign out = integ[NUM_STAGES-1];

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator with N=3, R=4 (STG_GSZ=2), ISZ=16, OSZ=20.
module tb_cic_interpolator;

  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned STG_GSZ    = 2;
  localparam int unsigned ISZ        = 16;
  localparam int unsigned OSZ        = ISZ + (NUM_STAGES - 1) * STG_GSZ;

  logic                  clk;
  logic                  reset;
  logic                  in_rate;
  logic                  out_rate;
  logic signed [ISZ-1:0] din;
  logic signed [OSZ-1:0] dout;
  logic                  out_valid;
  logic                  overrun;

  cic_interpolator #(
    .NUM_STAGES(NUM_STAGES),
    .STG_GSZ   (STG_GSZ),
    .ISZ       (ISZ)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_rate  (in_rate),
    .out_rate (out_rate),
    .in       (din),
    .out      (dout),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame = 8 clks: out_rate on even clks, one in_rate at clk 1 (or clk 0 when coincident).
  typedef struct {
    string name;
    bit    rst;
    bit    coinc;
    int    din;
    int    e0, e1, e2, e3;
  } vec_t;

  vec_t tbl[$];
  int   got[4];
  int   nvalid;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, actual, expected);
    end
  endtask

  task automatic cycle(input logic ir, input logic orr, input int d);
    in_rate  = ir;
    out_rate = orr;
    din      = ISZ'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    cycle(1'b0, 1'b0, 0);
    reset = 1'b0;
    check({nm, ".rst_out"}, int'(dout), 0);
    check({nm, ".rst_valid"}, int'(out_valid), 0);
    check({nm, ".rst_overrun"}, int'(overrun), 0);
  endtask

  task automatic run_frame(input bit coinc, input int d);
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(coinc ? (k == 0) : (k == 1), (k % 2) == 0, d);
      if (out_valid) begin
        if (nvalid < 4) got[nvalid] = int'(dout);
        nvalid++;
      end
    end
    in_rate  = 1'b0;
    out_rate = 1'b0;
  endtask

  function automatic void add(input string nm, input bit rst, input bit co, input int d,
                              input int a, input int b, input int c, input int e);
    vec_t v;
    v.name = nm; v.rst = rst; v.coinc = co; v.din = d;
    v.e0 = a; v.e1 = b; v.e2 = c; v.e3 = e;
    tbl.push_back(v);
  endfunction

  initial begin
    int ex[4];
    reset    = 1'b1;
    in_rate  = 1'b0;
    out_rate = 1'b0;
    din      = '0;

    // Impulse response 1,3,6,10,12,12,10,6,3,1 starting at the 6th output
    add("impulse", 1, 0, 1,  0, 0, 0, 0);
    add("impulse", 0, 0, 0,  0, 1, 3, 6);
    add("impulse", 0, 0, 0,  10, 12, 12, 10);
    add("impulse", 0, 0, 0,  6, 3, 1, 0);
    add("impulse", 0, 0, 0,  0, 0, 0, 0);
    // DC step: 100 * cumulative polyphase sums, settling at 100*R^(N-1)
    add("dc", 1, 0, 100,  0, 0, 0, 0);
    add("dc", 0, 0, 100,  0, 100, 300, 600);
    add("dc", 0, 0, 100,  1000, 1300, 1500, 1600);
    add("dc", 0, 0, 100,  1600, 1600, 1600, 1600);
    add("dc", 0, 0, 100,  1600, 1600, 1600, 1600);
    // Negative full scale settles at the 20-bit minimum
    add("negfs", 1, 0, -32768,  0, 0, 0, 0);
    add("negfs", 0, 0, -32768,  0, -32768, -98304, -196608);
    add("negfs", 0, 0, -32768,  -327680, -425984, -491520, -524288);
    add("negfs", 0, 0, -32768,  -524288, -524288, -524288, -524288);
    add("negfs", 0, 0, -32768,  -524288, -524288, -524288, -524288);
    // Coincident in_rate/out_rate: injection deferred to the next out_rate
    add("coinc", 1, 1, 1,  0, 0, 0, 0);
    add("coinc", 0, 1, 0,  0, 1, 3, 6);
    add("coinc", 0, 1, 0,  10, 12, 12, 10);
    add("coinc", 0, 1, 0,  6, 3, 1, 0);
    add("coinc", 0, 1, 0,  0, 0, 0, 0);
    add("coinc", 0, 1, 0,  0, 0, 0, 0);

    foreach (tbl[r]) begin
      string tag;
      if (tbl[r].rst) do_reset(tbl[r].name);
      run_frame(tbl[r].coinc, tbl[r].din);
      ex = '{tbl[r].e0, tbl[r].e1, tbl[r].e2, tbl[r].e3};
      tag = $sformatf("%s[%0d]", tbl[r].name, r);
      check({tag, ".nvalid"}, nvalid, 4);
      for (int k = 0; k < 4; k++) check($sformatf("%s.out%0d", tag, k), got[k], ex[k]);
      check({tag, ".overrun"}, int'(overrun), 0);
    end

    // Reset mid-impulse with a comb result still in flight
    do_reset("midrst");
    run_frame(1'b0, 1);
    run_frame(1'b0, 0);
    check("midrst.pre3", got[3], 6);
    cycle(1'b0, 1'b1, 0);
    check("midrst.fourth", int'(dout), 10);
    cycle(1'b1, 1'b0, 0);
    reset = 1'b1;
    cycle(1'b0, 1'b0, 0);
    reset = 1'b0;
    check("midrst.out", int'(dout), 0);
    check("midrst.valid", int'(out_valid), 0);
    check("midrst.overrun", int'(overrun), 0);
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 0);
      check($sformatf("midrst.f%0d.nvalid", f), nvalid, 4);
      for (int k = 0; k < 4; k++) check($sformatf("midrst.f%0d.out%0d", f, k), got[k], 0);
    end

    // Overrun: two samples with no out_rate between them; the second (comb value -8) wins
    do_reset("ovr");
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 5);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 7);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 0);
    check("ovr.before", int'(overrun), 0);
    cycle(1'b0, 1'b0, 0);
    check("ovr.set", int'(overrun), 1);
    cycle(1'b0, 1'b1, 0);
    check("ovr.out_a", int'(dout), 0);
    cycle(1'b0, 1'b1, 0);
    check("ovr.out_b", int'(dout), 0);
    cycle(1'b0, 1'b1, 0);
    check("ovr.out_c", int'(dout), -8);
    check("ovr.valid", int'(out_valid), 1);
    cycle(1'b0, 1'b1, 0);
    check("ovr.out_d", int'(dout), -24);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 0);
    check("ovr.sticky", int'(overrun), 1);
    do_reset("ovr_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
